// File: rtl/pulse_rate_meter_if.sv
// Signal bundle between a pulse source (master) and the rate meter (slave).
// meas_done is a one-cycle strobe with no back-pressure: period, rate_code and rate_valid are already updated in that cycle.
interface pulse_rate_meter_if #(
    parameter int unsigned CNT_W = 28
);
    logic             pulse_in;
    logic [CNT_W-1:0] period;
    logic             meas_done;
    logic [1:0]       rate_code;
    logic             rate_valid;
    logic             stalled;
    logic [1:0]       fsm_state;

    modport master (
        output pulse_in,
        input  period, meas_done, rate_code, rate_valid, stalled, fsm_state
    );

    modport slave (
        input  pulse_in,
        output period, meas_done, rate_code, rate_valid, stalled, fsm_state
    );
endinterface

// File: rtl/pulse_rate_meter.sv
// Measures the cycle interval between enable pulses and decodes it back to the
// 2-bit speed-select code; a code must repeat twice before it is confirmed.
module pulse_rate_meter #(
    parameter int unsigned CNT_W   = 28,
    parameter int unsigned RATE1   = 50_000_000,
    parameter int unsigned RATE2   = 100_000_000,
    parameter int unsigned RATE3   = 200_000_000,
    parameter int unsigned TOL     = 2,
    parameter int unsigned TIMEOUT = RATE3 + TOL + 1
) (
    input logic              Clock,
    input logic              reset,
    pulse_rate_meter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        STALL   = 2'd2
    } state_t;

    localparam int unsigned       W1      = CNT_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] period;
    logic             meas_done;
    logic [1:0]       rate_code;
    logic             rate_valid;
    logic             stalled;
    logic [1:0]       cand;
    logic             cand_ok;
    logic [1:0]       code;
    logic             code_ok;

    // One bit wider than the counter so |n - rate| never underflows.
    function automatic logic near(input logic [CNT_W-1:0] n, input int unsigned rate);
        logic [CNT_W:0] a;
        logic [CNT_W:0] r;
        logic [CNT_W:0] d;
        a = {1'b0, n};
        r = W1'(rate);
        d = (a >= r) ? (a - r) : (r - a);
        return d <= W1'(TOL);
    endfunction

    always_comb begin
        code    = 2'b00;
        code_ok = 1'b0;
        if (cnt == CNT_W'(1)) begin
            code    = 2'b00;
            code_ok = 1'b1;
        end else if (near(cnt, RATE1)) begin
            code    = 2'b01;
            code_ok = 1'b1;
        end else if (near(cnt, RATE2)) begin
            code    = 2'b10;
            code_ok = 1'b1;
        end else if (near(cnt, RATE3)) begin
            code    = 2'b11;
            code_ok = 1'b1;
        end
    end

    always_ff @(posedge Clock) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            period     <= '0;
            meas_done  <= 1'b0;
            rate_code  <= 2'b00;
            rate_valid <= 1'b0;
            stalled    <= 1'b0;
            cand       <= 2'b00;
            cand_ok    <= 1'b0;
        end else begin
            meas_done <= 1'b0;
            if (bus.pulse_in) begin
                cnt <= CNT_W'(1);
            end else if (state != STALL && cnt != CNT_MAX) begin
                cnt <= cnt + CNT_W'(1);
            end

            case (state)
                IDLE: begin
                    if (bus.pulse_in) state <= MEASURE;
                end
                MEASURE: begin
                    if (bus.pulse_in) begin
                        period    <= cnt;
                        meas_done <= 1'b1;
                        if (!code_ok) begin
                            cand_ok    <= 1'b0;
                            rate_valid <= 1'b0;
                        end else if (cand_ok && code == cand) begin
                            rate_code  <= code;
                            rate_valid <= 1'b1;
                        end else begin
                            cand       <= code;
                            cand_ok    <= 1'b1;
                            rate_valid <= 1'b0;
                        end
                    end else if (cnt == CNT_MAX) begin
                        state      <= STALL;
                        stalled    <= 1'b1;
                        rate_valid <= 1'b0;
                    end
                end
                STALL: begin
                    // The first pulse after a stall only restarts timing.
                    if (bus.pulse_in) begin
                        stalled <= 1'b0;
                        state   <= MEASURE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.period     = period;
    assign bus.meas_done  = meas_done;
    assign bus.rate_code  = rate_code;
    assign bus.rate_valid = rate_valid;
    assign bus.stalled    = stalled;
    assign bus.fsm_state  = state;
endmodule
